// File: rtl/riscv_ctrl_pkg.sv
// Shared constants for the RV pipeline controller: opcodes, immediate format codes and FSM states.
package riscv_ctrl_pkg;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_SD  = 7'b0100011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   typedef enum logic [1:0] {
      IMM_NONE = 2'd0,
      IMM_I    = 2'd1,
      IMM_S    = 2'd2,
      IMM_B    = 2'd3
   } imm_fmt_t;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RUN      = 2'd1,
      ST_MEM_WAIT = 2'd2,
      ST_ERROR    = 2'd3
   } state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side signals of the hazard controller; perf counter outputs appear only with HAZARD_PERF_EN.
interface pipeline_hazard_ctrl_if
`ifdef HAZARD_PERF_EN
   #(parameter int CNT_W = 32)
`endif
   ;

   logic        start_i;
   logic [31:0] instr_id_i;
   logic        idex_memread_i;
   logic [4:0]  idex_rd_i;
   logic        branch_taken_i;
   logic        dmem_req_i;
   logic        dmem_ack_i;

   logic        pc_write_o;
   logic        ifid_write_o;
   logic        ifid_flush_o;
   logic        idex_bubble_o;
   logic        exmem_hold_o;
   logic [1:0]  imm_fmt_o;
   logic        illegal_o;
   logic        err_o;
`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0] stall_cnt_o;
   logic [CNT_W-1:0] flush_cnt_o;
`endif

   modport slave (
      input  start_i, instr_id_i, idex_memread_i, idex_rd_i, branch_taken_i,
             dmem_req_i, dmem_ack_i,
      output pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, exmem_hold_o,
             imm_fmt_o, illegal_o, err_o
`ifdef HAZARD_PERF_EN
      , output stall_cnt_o, flush_cnt_o
`endif
   );

   modport master (
      output start_i, instr_id_i, idex_memread_i, idex_rd_i, branch_taken_i,
             dmem_req_i, dmem_ack_i,
      input  pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, exmem_hold_o,
             imm_fmt_o, illegal_o, err_o
`ifdef HAZARD_PERF_EN
      , input stall_cnt_o, flush_cnt_o
`endif
   );

endinterface

// File: rtl/hazard_op_decode.sv
// Combinational ID-stage opcode decode: immediate format, rs2 usage, branch flag and illegal flag.
module hazard_op_decode
   import riscv_ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   output imm_fmt_t   imm_fmt,
   output logic       uses_rs2,
   output logic       is_branch,
   output logic       illegal
);

   always_comb begin
      imm_fmt   = IMM_NONE;
      uses_rs2  = 1'b0;
      is_branch = 1'b0;
      illegal   = 1'b0;
      case (opcode)
         OP_R:        uses_rs2 = 1'b1;
         OP_I, OP_LD: imm_fmt  = IMM_I;
         OP_SD: begin
            imm_fmt  = IMM_S;
            uses_rs2 = 1'b1;
         end
         OP_BEQ: begin
            imm_fmt   = IMM_B;
            uses_rs2  = 1'b1;
            is_branch = 1'b1;
         end
         default:     illegal  = 1'b1;
      endcase
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: load-use bubbles, beq flush, memory freeze with timeout watchdog.
// Optional stall/flush performance counters are built when HAZARD_PERF_EN is defined.
module pipeline_hazard_ctrl
   import riscv_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16
`ifdef HAZARD_PERF_EN
   , parameter int CNT_W = 32
`endif
) (
   input logic                   clk_i,
   input logic                   rst_i,
   pipeline_hazard_ctrl_if.slave hz
);

   localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

   state_t     state;
   state_t     state_nxt;
   logic [7:0] wait_cnt;

   imm_fmt_t   imm_fmt;
   logic       uses_rs2;
   logic       is_branch;
   logic       illegal;
   logic       freeze;
   logic       advancing;
   logic       load_use;
   logic       flush;
   logic [4:0] rs1;
   logic [4:0] rs2;
   logic       unused_instr_bits;

   hazard_op_decode u_decode (
      .opcode    (hz.instr_id_i[6:0]),
      .imm_fmt   (imm_fmt),
      .uses_rs2  (uses_rs2),
      .is_branch (is_branch),
      .illegal   (illegal)
   );

   assign rs1               = hz.instr_id_i[19:15];
   assign rs2               = hz.instr_id_i[24:20];
   assign unused_instr_bits = ^{hz.instr_id_i[31:25], hz.instr_id_i[14:7]};

   always_comb begin
      freeze = 1'b0;
      case (state)
         ST_RUN:      freeze = hz.dmem_req_i & ~hz.dmem_ack_i;
         ST_MEM_WAIT: freeze = ~hz.dmem_ack_i;
         default:     freeze = 1'b0;
      endcase
   end

   // The ack cycle of a memory wait advances the pipe, so hazards are still honoured there.
   assign advancing = ((state == ST_RUN) || (state == ST_MEM_WAIT)) && !freeze;
   assign load_use  = advancing && hz.idex_memread_i && (hz.idex_rd_i != 5'd0) && !illegal &&
                      ((hz.idex_rd_i == rs1) || (uses_rs2 && (hz.idex_rd_i == rs2)));
   assign flush     = advancing && !load_use && hz.branch_taken_i && is_branch;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:     if (hz.start_i) state_nxt = ST_RUN;
         ST_RUN:      if (freeze) state_nxt = ST_MEM_WAIT;
         ST_MEM_WAIT: begin
            if (hz.dmem_ack_i) begin
               state_nxt = ST_RUN;
            end else if (wait_cnt == WAIT_LAST) begin
               state_nxt = ST_ERROR;
            end
         end
         ST_ERROR:    state_nxt = ST_ERROR;
         default:     state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wait_cnt <= 8'd0;
      end else if ((state == ST_MEM_WAIT) && (state_nxt == ST_MEM_WAIT)) begin
         wait_cnt <= wait_cnt + 8'd1;
      end else begin
         wait_cnt <= 8'd0;
      end
   end

   always_comb begin
      hz.pc_write_o    = 1'b1;
      hz.ifid_write_o  = 1'b1;
      hz.ifid_flush_o  = 1'b0;
      hz.idex_bubble_o = 1'b0;
      hz.exmem_hold_o  = 1'b0;
      case (state)
         ST_IDLE: begin
            hz.pc_write_o    = 1'b0;
            hz.ifid_write_o  = 1'b0;
            hz.idex_bubble_o = 1'b1;
         end
         ST_ERROR: begin
            hz.pc_write_o    = 1'b0;
            hz.ifid_write_o  = 1'b0;
            hz.idex_bubble_o = 1'b1;
            hz.exmem_hold_o  = 1'b1;
         end
         default: begin
            if (freeze) begin
               hz.pc_write_o   = 1'b0;
               hz.ifid_write_o = 1'b0;
               hz.exmem_hold_o = 1'b1;
            end else if (load_use) begin
               hz.pc_write_o    = 1'b0;
               hz.ifid_write_o  = 1'b0;
               hz.idex_bubble_o = 1'b1;
            end else if (flush) begin
               hz.ifid_flush_o = 1'b1;
            end
         end
      endcase
   end

   assign hz.imm_fmt_o = imm_fmt;
   assign hz.illegal_o = illegal;
   assign hz.err_o     = (state == ST_ERROR);

`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   // Both counters saturate rather than wrap so long runs never under-report.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if ((load_use || freeze) && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
         if (flush && (flush_cnt != '1))                flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

   assign hz.stall_cnt_o = stall_cnt;
   assign hz.flush_cnt_o = flush_cnt;
`endif

endmodule
